// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the two requesters, the arbiter and the memory.
// master: the requester/memory side; slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch side
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    // Load/store side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    // Status
    logic          err;
    logic          busy;

    // Memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  err, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output err, busy,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: I-side (fetch) and D-side
// (load/store). One access at a time, stall-tolerant, with a watchdog that
// aborts accesses the slave never completes. All outputs are registered.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_d_q, gnt_d_d;      // 1 = current access belongs to D-side
    logic          last_d_q, last_d_d;    // 1 = most recent grant went to D-side
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          grant;
    logic          pick_d;

    // Next-state and next-output computation for the IDLE/ACCESS/DONE sequencer
    always_comb begin
        state_d     = state_q;
        gnt_d_d     = gnt_d_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        grant       = 1'b0;
        pick_d      = 1'b0;
        cnt_inc     = cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    grant  = 1'b1;
                    pick_d = (ROUND_ROBIN != 0) ? !last_d_q : 1'b1;
                end else if (bus.d_req) begin
                    grant  = 1'b1;
                    pick_d = 1'b1;
                end else if (bus.i_req) begin
                    grant  = 1'b1;
                    pick_d = 1'b0;
                end

                if (grant) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    cnt_d    = '0;
                    mem_en_d = 1'b1;
                    state_d  = ACCESS;
                    if (pick_d) begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_addr_d  = bus.i_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end

            ACCESS: begin
                cnt_d = cnt_inc;
                // mem_ready is checked first so it wins over a same-cycle timeout
                if (bus.mem_ready) begin
                    if (gnt_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                    if (gnt_d_q) begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_ack_d   = 1'b1;
                    end
                    err_d    = 1'b1;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end
            end

            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_d_q     <= 1'b0;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_d_q     <= gnt_d_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two lanes (round-robin/TIMEOUT=16 and
// fixed-priority/TIMEOUT=5), each with a request driver, a memory responder
// and an ack monitor fed from scoreboard queues built by a grant-order model.
module tb_mem_port_arbiter;
    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int unsigned stall;
        logic [31:0] rd;
    } mem_item_t;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rd;
        logic        chk_rd;
    } ack_item_t;

    localparam int NR = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input int lane, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL L%0d %s: got %h expected %h", lane, name, act, exp);
        end
    endtask

    function automatic int unsigned pick_stall(input int unsigned to);
        int unsigned v;
        v = $urandom_range(9, 0);
        if (v < 7) return $urandom_range(3, 0);
        else if (v == 7) return to - 1;
        else if (v == 8) return to;
        else return to + 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int RR = (g == 0) ? 1 : 0;
        localparam int TO = (g == 0) ? 16 : 5;

        logic        rst;
        bit          done = 1'b0;
        bit          active = 1'b0;
        mem_item_t   cur;
        int unsigned cyc;
        ack_item_t   a;
        mem_item_t   mem_q[$];
        ack_item_t   ack_q[$];

        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        mem_port_arbiter #(
            .AW(32), .DW(32), .ROUND_ROBIN(RR), .TIMEOUT(TO)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        // Memory responder: checks each access and answers after its stall count
        initial begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            cyc = 0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    active = 1'b0;
                    bus.mem_ready = 1'b0;
                end else if (!active) begin
                    if (bus.mem_en) begin
                        if (mem_q.size() == 0) begin
                            check(g, "mem_unexpected", bus.mem_en, 1'b0);
                        end else begin
                            cur = mem_q.pop_front();
                            active = 1'b1;
                            cyc = 1;
                            check(g, "mem_addr", bus.mem_addr, cur.addr);
                            check(g, "mem_we", bus.mem_we, cur.we);
                            if (cur.we) check(g, "mem_wdata", bus.mem_wdata, cur.wdata);
                            bus.mem_ready = (cur.stall == 0);
                            bus.mem_rdata = (cur.stall == 0) ? cur.rd : $urandom;
                        end
                    end
                end else if (bus.mem_ready || cyc == unsigned'(TO)) begin
                    check(g, "mem_en_drop", bus.mem_en, 1'b0);
                    check(g, "ack_timing", cur.is_d ? bus.d_ack : bus.i_ack, 1'b1);
                    bus.mem_ready = 1'b0;
                    active = 1'b0;
                end else begin
                    cyc++;
                    check(g, "mem_en_hold", bus.mem_en, 1'b1);
                    check(g, "mem_addr_hold", bus.mem_addr, cur.addr);
                    check(g, "mem_we_hold", bus.mem_we, cur.we);
                    if (cur.we) check(g, "mem_wdata_hold", bus.mem_wdata, cur.wdata);
                    if (cyc == cur.stall + 1) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = cur.rd;
                    end else begin
                        bus.mem_rdata = $urandom;
                    end
                end
            end
        end

        // Ack monitor: pops the expected completion whenever an ack appears
        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (bus.i_ack || bus.d_ack) begin
                    check(g, "ack_exclusive", bus.i_ack & bus.d_ack, 1'b0);
                    if (ack_q.size() == 0) begin
                        check(g, "ack_unexpected", bus.i_ack | bus.d_ack, 1'b0);
                    end else begin
                        a = ack_q.pop_front();
                        check(g, "ack_side", bus.d_ack, a.is_d);
                        check(g, "ack_err", bus.err, a.err);
                        check(g, "ack_busy", bus.busy, 1'b1);
                        if (a.chk_rd)
                            check(g, "ack_rdata", a.is_d ? bus.d_rdata : bus.i_rdata, a.rd);
                    end
                end
            end
        end

        // Stimulus: builds each round, predicts grant order, drives requesters
        initial begin
            logic [31:0] ia [4];
            logic [31:0] ird [4];
            int unsigned ist [4];
            logic [31:0] da [4];
            logic        dwe [4];
            logic [31:0] dwd [4];
            logic [31:0] drd [4];
            int unsigned dst [4];
            int unsigned i_n, d_n, pi, pd, i_idx, d_idx, budget, j;
            logic        last, pick;
            mem_item_t   m;
            ack_item_t   k;

            rst = 1'b1;
            bus.i_req = 1'b0;   bus.i_addr = '0;
            bus.d_req = 1'b0;   bus.d_we = 1'b0;
            bus.d_addr = '0;    bus.d_wdata = '0;
            repeat (3) @(posedge clk);
            #1;
            check(g, "rst_mem_en", bus.mem_en, 1'b0);
            check(g, "rst_mem_we", bus.mem_we, 1'b0);
            check(g, "rst_mem_addr", bus.mem_addr, 32'h0);
            check(g, "rst_mem_wdata", bus.mem_wdata, 32'h0);
            check(g, "rst_busy", bus.busy, 1'b0);
            check(g, "rst_err", bus.err, 1'b0);
            check(g, "rst_i_ack", bus.i_ack, 1'b0);
            check(g, "rst_d_ack", bus.d_ack, 1'b0);
            check(g, "rst_i_rdata", bus.i_rdata, 32'h0);
            check(g, "rst_d_rdata", bus.d_rdata, 32'h0);
            rst = 1'b0;
            last = 1'b0;

            for (int r = 0; r < NR; r++) begin
                if (r == NR - 1) begin
                    // Abandon a fetch with a reset in its second ACCESS cycle
                    m.is_d = 1'b0; m.addr = 32'h80; m.we = 1'b0;
                    m.wdata = '0; m.stall = 50; m.rd = 32'hBAD0BAD0;
                    mem_q.push_back(m);
                    bus.i_req = 1'b1;
                    bus.i_addr = 32'h80;
                    budget = 0;
                    while (!active && budget < 20) begin
                        @(negedge clk);
                        budget++;
                    end
                    check(g, "rst_test_started", active, 1'b1);
                    @(posedge clk);
                    #1;
                    rst = 1'b1;
                    bus.i_req = 1'b0;
                    @(posedge clk);
                    #1;
                    check(g, "midrst_mem_en", bus.mem_en, 1'b0);
                    check(g, "midrst_busy", bus.busy, 1'b0);
                    check(g, "midrst_i_ack", bus.i_ack, 1'b0);
                    check(g, "midrst_i_rdata", bus.i_rdata, 32'h0);
                    check(g, "midrst_mem_addr", bus.mem_addr, 32'h0);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    last = 1'b0;
                    mem_q.delete();
                end

                for (int q = 0; q < 4; q++) begin
                    ia[q] = $urandom;   ird[q] = $urandom;  ist[q] = pick_stall(TO);
                    da[q] = $urandom;   dwe[q] = 1'($urandom_range(1, 0));
                    dwd[q] = $urandom;  drd[q] = $urandom;  dst[q] = pick_stall(TO);
                end
                i_n = 0;
                d_n = 0;
                case (r)
                    0: begin
                        d_n = 1; da[0] = 32'h100; dwe[0] = 1'b0;
                        dst[0] = 0; drd[0] = 32'hDEADBEEF;
                    end
                    1: begin
                        d_n = 1; da[0] = 32'h20; dwe[0] = 1'b1;
                        dwd[0] = 32'h12345678; dst[0] = 3;
                    end
                    2: begin
                        i_n = 1; ia[0] = 32'h40; ist[0] = TO + 5;
                    end
                    3: begin
                        i_n = 2; d_n = 2; ist[0] = 0; ist[1] = 0; dst[0] = 0; dst[1] = 0;
                    end
                    NR - 1: begin
                        i_n = 1; ia[0] = 32'h44; ist[0] = 1; ird[0] = 32'hCAFEF00D;
                    end
                    default: begin
                        i_n = $urandom_range(2, 0);
                        d_n = $urandom_range(3, 0);
                        if (i_n + d_n == 0) d_n = 1;
                    end
                endcase

                // Grant order: pending sides compete; RR alternates, else D wins
                pi = i_n;
                pd = d_n;
                while (pi > 0 || pd > 0) begin
                    if (pi > 0 && pd > 0) pick = (RR != 0) ? (last == 1'b0) : 1'b1;
                    else pick = (pd > 0);
                    if (pick) begin
                        j = d_n - pd;
                        m.is_d = 1'b1; m.addr = da[j]; m.we = dwe[j];
                        m.wdata = dwd[j]; m.stall = dst[j]; m.rd = drd[j];
                        pd--;
                    end else begin
                        j = i_n - pi;
                        m.is_d = 1'b0; m.addr = ia[j]; m.we = 1'b0;
                        m.wdata = '0; m.stall = ist[j]; m.rd = ird[j];
                        pi--;
                    end
                    last = pick;
                    k.is_d = pick;
                    k.err = (m.stall >= unsigned'(TO));
                    k.rd = k.err ? 32'h0 : m.rd;
                    k.chk_rd = !m.we;
                    mem_q.push_back(m);
                    ack_q.push_back(k);
                end

                i_idx = 0;
                d_idx = 0;
                bus.i_req = (i_n > 0);
                bus.i_addr = ia[0];
                bus.d_req = (d_n > 0);
                bus.d_we = dwe[0];
                bus.d_addr = da[0];
                bus.d_wdata = dwd[0];
                budget = 0;
                while (!(i_idx == i_n && d_idx == d_n && ack_q.size() == 0 && !active)
                       && budget < 600) begin
                    @(posedge clk);
                    #1;
                    budget++;
                    if (bus.i_ack && i_idx < i_n) begin
                        i_idx++;
                        if (i_idx < i_n) bus.i_addr = ia[i_idx];
                        else bus.i_req = 1'b0;
                    end
                    if (bus.d_ack && d_idx < d_n) begin
                        d_idx++;
                        if (d_idx < d_n) begin
                            bus.d_addr = da[d_idx];
                            bus.d_we = dwe[d_idx];
                            bus.d_wdata = dwd[d_idx];
                        end else begin
                            bus.d_req = 1'b0;
                        end
                    end
                end
                check(g, "round_complete", budget < 600, 1'b1);
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
                if (budget >= 600) begin
                    rst = 1'b1;
                    repeat (2) @(posedge clk);
                    #1;
                    mem_q.delete();
                    ack_q.delete();
                    rst = 1'b0;
                    last = 1'b0;
                end
                @(posedge clk);
                #1;
                check(g, "idle_busy", bus.busy, 1'b0);
            end
            done = 1'b1;
        end
    end

    initial begin
        wait (lane[0].done && lane[1].done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port memory between two requesters: the instruction-fetch path (I-side, driven when the FSM raises write_ir) and the load/store data path (D-side).
- Arbitrates between the two, sequences one memory access at a time, waits for a slave that can stall, and returns read data with a one-cycle acknowledge.
- A watchdog aborts accesses the slave never completes.
- Sits between the controller/datapath and the memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- ROUND_ROBIN, 1: 1 = alternate when both sides request; 0 = fixed priority, D-side first.
- TIMEOUT, 16: maximum ACCESS cycles before abort. 0 disables the watchdog. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  AW  fetch address; stable while i_req
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  DW  fetched word; valid when i_ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DW  load data; valid when d_ack
- err  out  1  high with ack when the access timed out
- busy  out  1  high in any state other than IDLE
- mem_en  out  1  access strobe
- mem_we  out  1  write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  slave completes the access this cycle

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: acks, err, busy, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata.
  - last_grant = I, so the first contended grant goes to D.
  - Watchdog counter is cleared.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - Requests are sampled only in IDLE.
  - Neither req: stay in IDLE.
  - Exactly one req: grant it.
  - Both reqs:
    - ROUND_ROBIN=1: grant the side that is not last_grant.
    - ROUND_ROBIN=0: grant D.
  - On a grant:
    - Latch the granted side, address, we and wdata. For I-side, we=0.
    - Set mem_en=1 and go to ACCESS.
    - last_grant is updated.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata hold the latched values.
  - Watchdog counter increments each cycle.
  - mem_ready=1:
    - Capture mem_rdata into the granted side's rdata register. Stores also capture it, and the value is don't-care.
    - Drop mem_en and go to DONE with err=0.
  - Counter reaches TIMEOUT with mem_ready still 0 (and TIMEOUT≠0):
    - Drop mem_en.
    - Granted rdata = 0, err=1, go to DONE.
  - If mem_ready arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins and err=0.
- DONE:
  - The granted side's ack=1 for exactly this cycle; err is valid in this cycle.
  - Return to IDLE and clear the counter.
  - rdata holds its value until the next completion on that side.
- Latency: req seen at edge N → mem_en high in cycle N+1 → with mem_ready in that cycle, ack in cycle N+2.
  - Each stall cycle adds one.
  - Minimum throughput is one access per 3 cycles.
- Requester rule: deassert req in the cycle after ack. If req is still high when IDLE samples it, a new access is issued.
- Request withdrawal: dropping req while not granted is allowed. After a grant, the access always completes; a dropped req does not cancel it.
- The ungranted side is never acked and its req stays pending.
- rst high mid-ACCESS: the access is abandoned; mem_en=0 next cycle and no ack is issued.
- busy = (state≠IDLE).

Test Plan:
1. Single load: d_req=1, d_we=0, d_addr=0x100, mem_ready in the first ACCESS cycle with mem_rdata=0xDEADBEEF → mem_en high for 1 cycle with mem_addr=0x100; d_ack pulses 2 cycles after the request is sampled; d_rdata=0xDEADBEEF; err=0.
2. Store with stall: d_we=1, d_addr=0x20, d_wdata=0x12345678, mem_ready asserted on the 4th ACCESS cycle → mem_we=1 and mem_wdata stable for all 4 cycles; a single d_ack; i_ack stays 0.
3. Contention, ROUND_ROBIN=1: i_req and d_req high together from reset, each re-requesting after its ack → grant order D, I, D, I; the two acks are never high in the same cycle.
4. Fixed priority, ROUND_ROBIN=0: both requesters permanently asserted → D is granted every time; I is served only after d_req drops.
5. Timeout, TIMEOUT=16: fetch to 0x40 with mem_ready tied 0 → mem_en high for exactly 16 cycles; i_ack=1 with err=1 and i_rdata=0; arbiter returns to IDLE.
6. Reset mid-access: rst pulsed in the 2nd ACCESS cycle → next cycle mem_en=0, busy=0, no ack; a subsequent fetch completes normally.
